// File: rtl/line_column_feeder_if.sv
// Pixel-stream-in / column-out bundle for line_column_feeder.
// master drives pixels and observes columns; slave is the feeder itself.
interface line_column_feeder_if #(
    parameter int DSIZE = 10,
    parameter int XW    = 7,
    parameter int YW    = 7
);
    logic [DSIZE-1:0]   pix_in;
    logic               pix_valid;
    logic               sof;
    logic [3*DSIZE-1:0] col_out;
    logic               col_valid;
    logic [XW-1:0]      x_cnt;
    logic [YW-1:0]      y_cnt;
    logic               frame_done;

    modport master (
        output pix_in, pix_valid, sof,
        input  col_out, col_valid, x_cnt, y_cnt, frame_done
    );

    modport slave (
        input  pix_in, pix_valid, sof,
        output col_out, col_valid, x_cnt, y_cnt, frame_done
    );
endinterface

// File: rtl/line_column_feeder.sv
// Line-buffer front end of the 3x3 window filter: keeps the two previous lines
// and emits one vertical 3-pixel column per pixel once two lines are buffered.
module line_column_feeder #(
    parameter int DSIZE   = 10,
    parameter int LWIDTH  = 10,
    parameter int FHEIGHT = 5,
    parameter int XW      = 7,
    parameter int YW      = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    line_column_feeder_if.slave  io_px
);
    localparam int AW = (LWIDTH > 1) ? $clog2(LWIDTH) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(LWIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FHEIGHT - 1);

    typedef enum logic [1:0] {
        FILL0 = 2'd0,
        FILL1 = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [XW-1:0]        r_x_cnt;
    logic [YW-1:0]        r_y_cnt;
    logic [XW-1:0]        w_x_next;
    logic [YW-1:0]        w_y_next;
    logic [3*DSIZE-1:0]   r_col_out;
    logic                 r_col_valid;
    logic                 r_frame_done;
    logic                 w_col_valid_next;
    logic                 w_frame_done_next;
    logic                 w_take;
    logic                 w_restart;
    logic                 w_line_wrap;
    logic                 w_frame_wrap;
    logic [AW-1:0]        w_idx;
    logic [DSIZE-1:0]     w_lb0_rd;
    logic [DSIZE-1:0]     w_lb1_rd;

    logic [DSIZE-1:0]     r_lb0 [LWIDTH];
    logic [DSIZE-1:0]     r_lb1 [LWIDTH];

    assign w_take       = io_px.pix_valid;
    assign w_restart    = io_px.pix_valid && io_px.sof;
    assign w_line_wrap  = w_take && !w_restart && (r_x_cnt == X_LAST);
    assign w_frame_wrap = w_line_wrap && (r_y_cnt == Y_LAST);

    // A start-of-frame pixel is always stored at column 0, whatever x_cnt says.
    assign w_idx    = w_restart ? '0 : r_x_cnt[AW-1:0];
    assign w_lb0_rd = r_lb0[w_idx];
    assign w_lb1_rd = r_lb1[w_idx];

    always_ff @(posedge clk) begin
        if (w_take) begin
            r_lb1[w_idx] <= r_lb0[w_idx];
            r_lb0[w_idx] <= io_px.pix_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FILL0;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_x_next          = r_x_cnt;
        w_y_next          = r_y_cnt;
        w_col_valid_next  = 1'b0;
        w_frame_done_next = 1'b0;

        if (w_restart) begin
            w_state_next = FILL0;
            w_x_next     = XW'(1);
            w_y_next     = '0;
        end else if (w_take) begin
            w_col_valid_next  = (r_state == RUN);
            w_frame_done_next = w_frame_wrap;
            if (w_frame_wrap) begin
                w_state_next = FILL0;
                w_x_next     = '0;
                w_y_next     = '0;
            end else if (w_line_wrap) begin
                w_x_next = '0;
                w_y_next = r_y_cnt + YW'(1);
                unique case (r_state)
                    FILL0:   w_state_next = FILL1;
                    FILL1:   w_state_next = RUN;
                    default: w_state_next = RUN;
                endcase
            end else begin
                w_x_next = r_x_cnt + XW'(1);
            end
        end
    end

    // col_out tracks every accepted pixel; only col_valid is gated by fill state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x_cnt      <= '0;
            r_y_cnt      <= '0;
            r_col_out    <= '0;
            r_col_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_x_cnt      <= w_x_next;
            r_y_cnt      <= w_y_next;
            r_col_valid  <= w_col_valid_next;
            r_frame_done <= w_frame_done_next;
            if (w_take) begin
                r_col_out <= {w_lb1_rd, w_lb0_rd, io_px.pix_in};
            end
        end
    end

    assign io_px.col_out    = r_col_out;
    assign io_px.col_valid  = r_col_valid;
    assign io_px.x_cnt      = r_x_cnt;
    assign io_px.y_cnt      = r_y_cnt;
    assign io_px.frame_done = r_frame_done;
endmodule
